// File: rtl/bp_fe_cmd_scheduler.sv
// FE command scheduler: single-entry redirect slot with strict priority over an attaboy FIFO.
// Optional macro BP_FE_CMD_SCHED_FLUSH_EN: a redirect transfer flushes the attaboy FIFO.
module bp_fe_cmd_scheduler #(
  parameter int unsigned cmd_width_p      = 128,
  parameter int unsigned attaboy_els_p    = 4,
  parameter int unsigned drop_cnt_width_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [cmd_width_p-1:0]      cmd_i,
  input  logic                        cmd_attaboy_i,
  input  logic                        cmd_v_i,
  output logic                        cmd_ready_and_o,
  output logic [cmd_width_p-1:0]      cmd_o,
  output logic                        cmd_attaboy_o,
  output logic                        cmd_v_o,
  input  logic                        cmd_yumi_i,
  output logic [drop_cnt_width_p-1:0] drop_cnt_o,
  output logic                        idle_o
);

  localparam int unsigned ptr_w = $clog2(attaboy_els_p);
  localparam int unsigned cnt_w = ptr_w + 1;
  localparam int unsigned sum_w = drop_cnt_width_p + cnt_w + 1;

  logic                        redir_v_r;
  logic [cmd_width_p-1:0]      redir_r;
  logic [cmd_width_p-1:0]      mem [attaboy_els_p];
  logic [ptr_w-1:0]            rd_ptr_r, wr_ptr_r;
  logic [cnt_w-1:0]            count_r;
  logic [drop_cnt_width_p-1:0] drop_cnt_r;

  logic fifo_v, full, xfer, redir_xfer, ab_xfer, redir_yumi, ab_deq, ab_enq, ab_drop, flush;
  logic [cnt_w-1:0]            flush_drops, drop_add;
  logic [sum_w-1:0]            drop_sum;
  logic [drop_cnt_width_p-1:0] drop_next;

  assign fifo_v     = (count_r != '0);
  assign full       = (count_r == cnt_w'(attaboy_els_p));
  assign cmd_ready_and_o = ~redir_v_r & reset_n_i;
  assign xfer       = cmd_v_i & cmd_ready_and_o;
  assign redir_xfer = xfer & ~cmd_attaboy_i;
  assign ab_xfer    = xfer & cmd_attaboy_i;
  assign redir_yumi = cmd_yumi_i & redir_v_r;
  assign ab_deq     = cmd_yumi_i & ~redir_v_r & fifo_v;
  // A full FIFO still accepts when its head leaves in the same cycle
  assign ab_enq     = ab_xfer & (~full | ab_deq);
  assign ab_drop    = ab_xfer & ~ab_enq;

`ifdef BP_FE_CMD_SCHED_FLUSH_EN
  assign flush       = redir_xfer;
  assign flush_drops = count_r - cnt_w'(ab_deq);
`else
  assign flush       = 1'b0;
  assign flush_drops = '0;
`endif

  // Saturating drop accumulation; flush and single discard never coincide
  always_comb begin
    drop_add  = flush ? flush_drops : cnt_w'(ab_drop);
    drop_sum  = sum_w'(drop_cnt_r) + sum_w'(drop_add);
    drop_next = drop_sum[drop_cnt_width_p-1:0];
    if (drop_sum > sum_w'({drop_cnt_width_p{1'b1}})) drop_next = {drop_cnt_width_p{1'b1}};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      redir_v_r  <= 1'b0;
      redir_r    <= '0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      drop_cnt_r <= '0;
    end else begin
      if (redir_xfer) begin
        redir_v_r <= 1'b1;
        redir_r   <= cmd_i;
      end else if (redir_yumi) begin
        redir_v_r <= 1'b0;
      end
      if (flush) begin
        rd_ptr_r <= '0;
        wr_ptr_r <= '0;
        count_r  <= '0;
      end else begin
        if (ab_deq) rd_ptr_r <= rd_ptr_r + ptr_w'(1);
        if (ab_enq) wr_ptr_r <= wr_ptr_r + ptr_w'(1);
        count_r <= count_r + cnt_w'(ab_enq) - cnt_w'(ab_deq);
      end
      drop_cnt_r <= drop_next;
    end
  end

  // Payload storage needs no reset; count gates visibility
  always_ff @(posedge clk_i) begin
    if (ab_enq) mem[wr_ptr_r] <= cmd_i;
  end

  always_comb begin
    cmd_o         = '0;
    cmd_attaboy_o = 1'b0;
    cmd_v_o       = 1'b0;
    if (redir_v_r) begin
      cmd_o   = redir_r;
      cmd_v_o = 1'b1;
    end else if (fifo_v) begin
      cmd_o         = mem[rd_ptr_r];
      cmd_attaboy_o = 1'b1;
      cmd_v_o       = 1'b1;
    end
  end

  assign drop_cnt_o = drop_cnt_r;
  assign idle_o     = ~redir_v_r & ~fifo_v;

endmodule

// File: tb/tb_bp_fe_cmd_scheduler.sv
// Self-checking bench for bp_fe_cmd_scheduler: queue-based reference model plus directed literal checks.
module tb_bp_fe_cmd_scheduler;
  localparam int unsigned W   = 16;
  localparam int unsigned ELS = 4;
  localparam int unsigned DW  = 3;
  localparam int unsigned DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b0;
  logic [W-1:0]  cmd_i = '0;
  logic          cmd_attaboy_i = 1'b0, cmd_v_i = 1'b0, cmd_yumi_i = 1'b0;
  logic          cmd_ready_and_o, cmd_attaboy_o, cmd_v_o, idle_o;
  logic [W-1:0]  cmd_o;
  logic [DW-1:0] drop_cnt_o;

  bp_fe_cmd_scheduler #(.cmd_width_p(W), .attaboy_els_p(ELS), .drop_cnt_width_p(DW)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .cmd_i(cmd_i), .cmd_attaboy_i(cmd_attaboy_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_and_o(cmd_ready_and_o), .cmd_o(cmd_o),
    .cmd_attaboy_o(cmd_attaboy_o), .cmd_v_o(cmd_v_o), .cmd_yumi_i(cmd_yumi_i),
    .drop_cnt_o(drop_cnt_o), .idle_o(idle_o));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic         m_rv;
  logic [W-1:0] m_r;
  logic [W-1:0] m_q[$];
  int           m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_valid();
    return m_rv || (m_q.size() > 0);
  endfunction

  // One cycle: drive at negedge, compare against model, advance model, wait to next negedge
  task automatic step(input logic v, input logic ab, input logic [W-1:0] d, input logic y);
    logic ev, eab, eidle, erdy, yy;
    logic [W-1:0] eo;
    yy = y && m_valid();
    cmd_v_i = v; cmd_attaboy_i = ab; cmd_i = d; cmd_yumi_i = yy;
    #1;
    erdy  = !m_rv;
    ev    = m_valid();
    eo    = m_rv ? m_r : (m_q.size() > 0 ? m_q[0] : '0);
    eab   = !m_rv && (m_q.size() > 0);
    eidle = !ev;
    chk("cycle_outputs",
        {cmd_ready_and_o, cmd_v_o, cmd_attaboy_o, idle_o, 4'(drop_cnt_o), 16'(cmd_o)},
        {erdy, ev, eab, eidle, 4'(m_drop), 16'(eo)});
    if (yy) begin
      if (m_rv) m_rv = 1'b0;
      else void'(m_q.pop_front());
    end
    if (v && erdy) begin
      if (!ab) begin
        m_rv = 1'b1; m_r = d;
`ifdef BP_FE_CMD_SCHED_FLUSH_EN
        m_drop += m_q.size();
        m_q.delete();
`endif
      end else if (m_q.size() < ELS) m_q.push_back(d);
      else m_drop++;
    end
    if (m_drop > DMAX) m_drop = DMAX;
    @(posedge clk);
    @(negedge clk);
    cmd_v_i = 1'b0; cmd_yumi_i = 1'b0;
  endtask

  task automatic do_reset();
    cmd_v_i = 1'b0; cmd_yumi_i = 1'b0;
    reset_n_i = 1'b0;
    #1;
    chk("rst_v", 32'(cmd_v_o), 0);
    chk("rst_o", 32'(cmd_o), 0);
    chk("rst_ab", 32'(cmd_attaboy_o), 0);
    chk("rst_ready", 32'(cmd_ready_and_o), 0);
    chk("rst_drop", 32'(drop_cnt_o), 0);
    m_rv = 1'b0; m_r = '0; m_q.delete(); m_drop = 0;
    @(posedge clk);
    @(negedge clk);
    reset_n_i = 1'b1;
    #1;
    chk("post_rst_ready", 32'(cmd_ready_and_o), 1);
    chk("post_rst_idle", 32'(idle_o), 1);
    @(negedge clk);
  endtask

  initial begin
    m_rv = 1'b0; m_r = '0; m_drop = 0;
    @(negedge clk);
    do_reset();

    // Redirect: accept, present next cycle, yumi, ready again after
    step(1, 0, 16'h00A5, 0);
    chk("redir_v", 32'(cmd_v_o), 1);
    chk("redir_o", 32'(cmd_o), 32'h00A5);
    step(0, 0, 0, 1);
    chk("redir_ready_back", 32'(cmd_ready_and_o), 1);
    chk("redir_idle", 32'(idle_o), 1);

    // Six attaboys into a depth-4 FIFO: two dropped, first four drain in order
    for (int i = 1; i <= 6; i++) begin
      chk("ab_ready", 32'(cmd_ready_and_o), 1);
      step(1, 1, 16'(i), 0);
    end
    chk("ab_drop2", 32'(drop_cnt_o), 2);
    for (int i = 1; i <= 4; i++) begin
      chk("ab_order", 32'(cmd_o), 32'(i));
      step(0, 0, 0, 1);
    end
    chk("ab_drained_idle", 32'(idle_o), 1);

    // Redirect preempting buffered attaboys
    do_reset();
    step(1, 1, 16'h0001, 0);
    step(1, 1, 16'h0002, 0);
    step(1, 0, 16'h0BEE, 0);
    chk("preempt_o", 32'(cmd_o), 32'h0BEE);
    chk("preempt_ab", 32'(cmd_attaboy_o), 0);
    step(0, 0, 0, 1);
`ifdef BP_FE_CMD_SCHED_FLUSH_EN
    chk("flush_idle", 32'(idle_o), 1);
    chk("flush_drop", 32'(drop_cnt_o), 2);
`else
    chk("drain1", 32'(cmd_o), 32'h0001);
    step(0, 0, 0, 1);
    chk("drain2", 32'(cmd_o), 32'h0002);
    step(0, 0, 0, 1);
    chk("drain_idle", 32'(idle_o), 1);
`endif

    // Full FIFO with simultaneous dequeue and enqueue
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 1, 16'(16 + i), 0);
    step(1, 1, 16'h0099, 1);
    chk("full_swap_drop", 32'(drop_cnt_o), 0);
    for (int i = 0; i < 4; i++) begin
      chk("full_swap_order", 32'(cmd_o), (i < 3) ? 32'(18 + i) : 32'h0099);
      step(0, 0, 0, 1);
    end

    // Saturating drop counter, then reset mid-stream
    do_reset();
    for (int i = 0; i < ELS + DMAX + 3; i++) step(1, 1, 16'(i), 0);
    chk("drop_sat", 32'(drop_cnt_o), DMAX);
    step(1, 0, 16'h0777, 0);
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                16'($urandom), 1'($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
